// File: rtl/scan_responder.sv
// scan_responder: scan-chain endpoint; shifts chain data, latches design inputs, captures design outputs.
// Latency: events act SYNC_STAGES clk edges after a raw level is first sampled; scan_data_out lags sr by one more.
// Backpressure: none; all scan inputs are oversampled levels and must each be held >= SYNC_STAGES+1 clk cycles.
`timescale 1ns/1ps
module scan_responder #(
  parameter int NUM_IOS     = 8,
  parameter int FRAME_BITS  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               scan_clk,
  input  logic               scan_data_in,
  input  logic               scan_select,
  input  logic               scan_latch_enable,
  output logic               scan_data_out,
  output logic [NUM_IOS-1:0] design_inputs,
  input  logic [NUM_IOS-1:0] design_outputs,
  output logic               latch_strobe,
  output logic               capture_strobe,
  output logic               frame_ok
);

  // Counter saturates one past a full frame so an over-long frame never wraps back to "exact".
  localparam int CW = $clog2(FRAME_BITS + 2);
  localparam logic [CW-1:0] CNT_FRAME = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_MAX   = CW'(FRAME_BITS + 1);

  // Bit order inside each sync stage: {latch_enable, select, data, clk}.
  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0]                  sync_out;
  logic                        clk_s, data_s, sel_s, le_s;
  logic                        clk_prev, sel_prev, le_prev;
  logic                        shift_ev, capture_ev, latch_ev, shift_do;
  logic [NUM_IOS-1:0]          sr;
  logic [CW-1:0]               shift_count;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign clk_s    = sync_out[0];
  assign data_s   = sync_out[1];
  assign sel_s    = sync_out[2];
  assign le_s     = sync_out[3];

  // Edge decode on synchronized levels; capture takes priority over a coincident shift.
  always_comb begin
    shift_ev   = clk_s & ~clk_prev & sel_s;
    capture_ev = ~sel_s & sel_prev;
    latch_ev   = le_s & ~le_prev;
    shift_do   = shift_ev & ~capture_ev;
  end

  // Synchronizers plus one "previous" flop per control for edge detection; data shares the same delay.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      clk_prev <= 1'b0;
      sel_prev <= 1'b0;
      le_prev  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0],
                   {scan_latch_enable, scan_select, scan_data_in, scan_clk}};
      clk_prev <= clk_s;
      sel_prev <= sel_s;
      le_prev  <= le_s;
    end
  end

  // Shift register: capture loads design outputs, otherwise shift in MSB-first chain data.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr            <= '0;
      scan_data_out <= 1'b0;
    end else begin
      scan_data_out <= sr[NUM_IOS-1];
      if (capture_ev) begin
        sr <= design_outputs;
      end else if (shift_do) begin
        sr <= {sr[NUM_IOS-2:0], data_s};
      end
    end
  end

  // Latch applies the pre-update sr and judges frame length; a coincident shift counts into the new frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      design_inputs <= '0;
      frame_ok      <= 1'b0;
      shift_count   <= '0;
    end else if (latch_ev) begin
      design_inputs <= sr;
      frame_ok      <= (shift_count == CNT_FRAME);
      shift_count   <= {{(CW-1){1'b0}}, shift_do};
    end else if (shift_do && (shift_count != CNT_MAX)) begin
      shift_count   <= shift_count + 1'b1;
    end
  end

  // One-cycle event strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      latch_strobe   <= 1'b0;
      capture_strobe <= 1'b0;
    end else begin
      latch_strobe   <= latch_ev;
      capture_strobe <= capture_ev;
    end
  end

endmodule

// File: tb/tb_scan_responder.sv
// tb_scan_responder: directed vectors for two chained scan_responder instances.
// Inputs are driven just after the falling clk edge and held 4 cycles per level.
// Outputs are sampled on the falling edge, away from the active edge.
`timescale 1ns/1ps
module tb_scan_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       scan_clk, scan_data_in, scan_select, scan_latch_enable;
  logic [7:0] design_outputs;

  logic       up_sdo, up_ls, up_cs, up_fok;
  logic [7:0] up_di;
  logic       dn_sdo, dn_ls, dn_cs, dn_fok;
  logic [7:0] dn_di;

  int checks = 0;
  int errors = 0;
  int ls_cnt = 0;
  int cs_cnt = 0;

  always #5 clk = ~clk;

  scan_responder u_up (
    .clk(clk), .reset(reset), .scan_clk(scan_clk), .scan_data_in(scan_data_in),
    .scan_select(scan_select), .scan_latch_enable(scan_latch_enable),
    .scan_data_out(up_sdo), .design_inputs(up_di), .design_outputs(design_outputs),
    .latch_strobe(up_ls), .capture_strobe(up_cs), .frame_ok(up_fok)
  );

  scan_responder u_dn (
    .clk(clk), .reset(reset), .scan_clk(scan_clk), .scan_data_in(up_sdo),
    .scan_select(scan_select), .scan_latch_enable(scan_latch_enable),
    .scan_data_out(dn_sdo), .design_inputs(dn_di), .design_outputs(design_outputs),
    .latch_strobe(dn_ls), .capture_strobe(dn_cs), .frame_ok(dn_fok)
  );

  // Strobe-high cycle counters; a single one-cycle pulse adds exactly 1.
  always @(posedge clk) begin
    if (up_ls) ls_cnt++;
    if (up_cs) cs_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One chain bit: data set with clk low, downstream output sampled just before the rise.
  task automatic shift_bit(input logic b, output logic so);
    scan_data_in = b;
    scan_clk     = 1'b0;
    cyc(4);
    so       = up_sdo;
    scan_clk = 1'b1;
    cyc(4);
    scan_clk = 1'b0;
  endtask

  task automatic shift_byte(input logic [7:0] v);
    logic so;
    for (int i = 7; i >= 0; i--) shift_bit(v[i], so);
  endtask

  task automatic pulse_latch();
    scan_latch_enable = 1'b1;
    cyc(4);
    scan_latch_enable = 1'b0;
    cyc(4);
  endtask

  initial begin
    logic       so;
    logic [7:0] rd;
    int         l0, c0;

    reset = 1'b1; scan_clk = 1'b0; scan_data_in = 1'b0;
    scan_select = 1'b0; scan_latch_enable = 1'b0; design_outputs = 8'h00;
    cyc(3);
    check("rst_outs", {23'd0, up_sdo, up_ls, up_cs, up_fok, up_di}, 32'h0);
    reset = 1'b0;
    cyc(2);

    // scan_clk rising with select low must not count.
    shift_bit(1'b1, so);
    cyc(4);
    check("ign_cnt", 32'(u_up.shift_count), 32'd0);

    // Load
    scan_select = 1'b1;
    cyc(4);
    l0 = ls_cnt;
    shift_byte(8'hA6);
    pulse_latch();
    check("load_di", 32'(up_di), 32'hA6);
    check("load_ls", 32'(ls_cnt - l0), 32'd1);
    check("load_fok", 32'(up_fok), 32'd0);

    // Full frame
    for (int i = 0; i < 24; i++) shift_bit(i[0], so);
    shift_byte(8'h3C);
    pulse_latch();
    check("frame_di", 32'(up_di), 32'h3C);
    check("frame_fok", 32'(up_fok), 32'd1);
    pulse_latch();
    check("relatch_fok", 32'(up_fok), 32'd0);
    check("relatch_di", 32'(up_di), 32'h3C);

    // Capture / read back
    design_outputs = 8'hC5;
    c0 = cs_cnt;
    scan_select = 1'b0;
    cyc(4);
    scan_select = 1'b1;
    cyc(4);
    check("cap_strobe", 32'(cs_cnt - c0), 32'd1);
    rd = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      shift_bit(1'b0, so);
      rd[i] = so;
    end
    check("cap_read", 32'(rd), 32'hC5);

    // Pass-through across the chain
    shift_byte(8'h12);
    shift_byte(8'h34);
    pulse_latch();
    check("chain_up", 32'(up_di), 32'h34);
    check("chain_dn", 32'(dn_di), 32'h12);

    // Collision: capture with scan_clk rise
    pulse_latch();
    for (int i = 0; i < 3; i++) shift_bit(1'b1, so);
    design_outputs = 8'h5A;
    scan_select = 1'b0;
    scan_clk    = 1'b1;
    cyc(4);
    check("coll_cap_sr", 32'(u_up.sr), 32'h5A);
    check("coll_cap_cnt", 32'(u_up.shift_count), 32'd3);
    scan_clk    = 1'b0;
    scan_select = 1'b1;
    cyc(4);

    // Collision: latch with shift
    scan_data_in = 1'b1;
    cyc(4);
    scan_clk          = 1'b1;
    scan_latch_enable = 1'b1;
    cyc(4);
    check("coll_lat_di", 32'(up_di), 32'h5A);
    check("coll_lat_cnt", 32'(u_up.shift_count), 32'd1);
    check("coll_lat_sr", 32'(u_up.sr), 32'hB5);
    scan_clk          = 1'b0;
    scan_latch_enable = 1'b0;
    cyc(4);

    // Reset mid-frame
    shift_bit(1'b1, so); shift_bit(1'b0, so); shift_bit(1'b1, so);
    shift_bit(1'b1, so); shift_bit(1'b0, so);
    reset = 1'b1;
    cyc(1);
    check("mid_rst_outs", {23'd0, up_sdo, up_ls, up_cs, up_fok, up_di}, 32'h0);
    check("mid_rst_state", {18'd0, 6'(u_up.shift_count), u_up.sr}, 32'h0);
    reset = 1'b0;
    cyc(4);
    shift_byte(8'hFF);
    pulse_latch();
    check("post_rst_di", 32'(up_di), 32'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_responder.md
# scan_responder

Per-design endpoint of the scan chain: receives the serial chain signals driven by the scan controller, shifts chain data through an internal NUM_IOS-bit register, applies latched inputs to the attached user design, and captures the design's outputs back into the chain. All scan signals are treated as asynchronous, oversampled levels in the local clock domain, so the block runs entirely on one system clock. Instances are daisy-chained: each instance's `scan_data_out` feeds the next instance's `scan_data_in`.

## Interface

- `NUM_IOS`, 8: design I/O width and per-stage shift length.
- `FRAME_BITS`, 32: expected shift count between latches (NUM_IOS × designs in chain).
- `SYNC_STAGES`, 2: synchronizer depth on every scan input, minimum 2.

Ports:

- `clk` in 1: system clock. One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `scan_clk` in 1: chain shift clock, sampled as data.
- `scan_data_in` in 1: serial chain data from the upstream stage.
- `scan_select` in 1: 1 = shift; falling edge = capture design outputs.
- `scan_latch_enable` in 1: rising edge = apply shift register to design inputs.
- `scan_data_out` out 1: serial chain data to the downstream stage.
- `design_inputs` out NUM_IOS: latched inputs to the user design.
- `design_outputs` in NUM_IOS: user design outputs, captured on request.
- `latch_strobe` out 1: one-cycle pulse when `design_inputs` updates.
- `capture_strobe` out 1: one-cycle pulse when outputs are captured.
- `frame_ok` out 1: registered at each latch; 1 if exactly FRAME_BITS shifts since the previous latch.

## Operation

- Input path: `scan_clk`, `scan_data_in`, `scan_select`, `scan_latch_enable` each pass through SYNC_STAGES flops. One extra "previous" flop per control signal provides edge detection. Data and controls share identical delay, so data is aligned with the clock edge that samples it.
- Events are evaluated each cycle from the synchronized values:
  - SHIFT: `scan_clk` rising and `scan_select`=1. `sr <= {sr[NUM_IOS-2:0], data_sync}`; `shift_count` increments, saturating at FRAME_BITS+1.
  - CAPTURE: `scan_select` falling. `sr <= design_outputs`; `capture_strobe`=1.
  - LATCH: `scan_latch_enable` rising. `design_inputs <= sr`; `frame_ok <= (shift_count == FRAME_BITS)`; `shift_count <= 0`; `latch_strobe`=1.
- `scan_clk` rising while `scan_select`=0 is ignored (no shift, no count).
- Simultaneous events:
  - CAPTURE and SHIFT in the same cycle: CAPTURE wins, the shift is dropped, and the count is not incremented.
  - LATCH with SHIFT or CAPTURE: LATCH uses the pre-update `sr`, and the other event proceeds. If LATCH and SHIFT coincide, `shift_count` ends at 1.
- `scan_data_out` is registered: `sr[NUM_IOS-1]`. The first bit shifted in exits after NUM_IOS shifts, so the bit order is MSB first.
- Reset:
  - Clears all sync flops, previous flops, `sr`, `shift_count`, `design_inputs`, `frame_ok`, `latch_strobe`, `capture_strobe` and `scan_data_out` to 0.
  - Reset mid-frame discards partial shifts.
  - The previous-flop value of 0 means a `scan_select` or `scan_latch_enable` that is already high at reset release produces no falling-edge event. It does produce a rising-edge event once synchronized: LATCH fires, loading 0s into `design_inputs`, so that is harmless.

## Timing

- A raw input level first sampled at edge N reaches the sync output at edge N+SYNC_STAGES−1. The resulting event updates `sr`, `design_inputs` and the strobes at edge N+SYNC_STAGES.
- `scan_data_out` follows `sr` one cycle later, at edge N+SYNC_STAGES+1.
- Strobes are exactly one cycle wide.
- Oversampling requirement: every level of every scan input must be held ≥ SYNC_STAGES+1 `clk` cycles. With the controller toggling `scan_clk` once per controller cycle, `clk` must be ≥ 3× the controller clock for the default parameters. Narrower pulses are out of spec and may be missed.
- `scan_data_in` must be stable for the same window around each `scan_clk` rising edge.

## Test plan

- **Load:** reset, then shift 8 bits 1,0,1,0,0,1,1,0 with select=1, then pulse latch. `design_inputs` = 8'hA6, one `latch_strobe`, `frame_ok`=0 (8 ≠ 32).
- **Full frame:** shift 32 bits, last 8 = 8'h3C, then latch. `design_inputs` = 8'h3C and `frame_ok`=1. Latch again with no shifts: `frame_ok`=0.
- **Capture/read:** `design_outputs`=8'hC5, drop select for 4 cycles then raise it. `capture_strobe` pulses once. The next 8 shifts present 1,1,0,0,0,1,0,1 on `scan_data_out`.
- **Pass-through:** two instances chained, shift 16 bits 8'h12 then 8'h34, latch. Upstream instance = 8'h34, downstream = 8'h12.
- **Collisions:** CAPTURE coincident with a `scan_clk` rise: `sr` = `design_outputs` and the count is unchanged. LATCH coincident with SHIFT: `design_inputs` = old `sr` and `shift_count` = 1.
- **Reset mid-frame:** reset after 5 shifts of a pattern. All outputs are 0 the next cycle, and a subsequent 8-bit load of 8'hFF latches 8'hFF.
